// File: rtl/obj_line_buffer.sv
// Ping-pong sprite line buffer: one bank collects the next line from the renderer while the
// other bank is scanned out by hpos and erased behind the beam.
module obj_line_buffer #(
  parameter int DW         = 15,
  parameter int AW         = 9,
  parameter int PEN_W      = 4,
  parameter int FIRST_WINS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pxl_cen,
  input  logic          lhbl,
  input  logic [8:0]    hpos,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          line_swap,
  output logic [DW-1:0] rd_data
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] init_cnt_reg, init_cnt_next;
  logic          init_active;

  logic          bank_sel_reg;
  logic          lhbl_last_reg;
  logic          s1_valid_reg, s1_bank_reg;
  logic [AW-1:0] s1_addr_reg;
  logic [DW-1:0] s1_data_reg;
  logic          fwd_valid_reg;
  logic [DW-1:0] fwd_data_reg;
  logic          er_valid_reg, er_bank_reg;
  logic [AW-1:0] er_addr_reg;

  logic [1:0][DW-1:0] bank_q;
  logic [DW-1:0] target_word;
  logic          swap, accept, scan_rd, commit;
  logic [AW-1:0] scan_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    init_active   = 1'b0;
    wr_ready      = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_active   = 1'b1;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == '1) state_next = ST_RUN;
      end
      ST_RUN:  wr_ready = !reset;
      default: state_next = ST_INIT;
    endcase
  end

  assign swap      = pxl_cen & ~lhbl & lhbl_last_reg;
  assign line_swap = swap & ~reset;
  assign accept    = wr_en & wr_ready;
  assign scan_rd   = pxl_cen & lhbl;
  assign scan_addr = hpos[AW-1:0];

  // The RAM read issued one clk earlier misses a commit to the same word landing in that clk.
  assign target_word = fwd_valid_reg ? fwd_data_reg : bank_q[s1_bank_reg];
  assign commit = s1_valid_reg && (s1_data_reg[PEN_W-1:0] != '0) &&
                  ((FIRST_WINS == 0) || (target_word[PEN_W-1:0] == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel_reg  <= 1'b0;
      lhbl_last_reg <= 1'b0;
      rd_data       <= '0;
      s1_valid_reg  <= 1'b0;
      fwd_valid_reg <= 1'b0;
      er_valid_reg  <= 1'b0;
    end else begin
      if (pxl_cen) begin
        lhbl_last_reg <= lhbl;
        rd_data       <= lhbl_last_reg ? bank_q[bank_sel_reg] : '0;
      end
      if (swap) bank_sel_reg <= ~bank_sel_reg;
      s1_valid_reg  <= accept;
      s1_addr_reg   <= wr_addr;
      s1_data_reg   <= wr_data;
      s1_bank_reg   <= ~bank_sel_reg;
      fwd_valid_reg <= commit && accept && (wr_addr == s1_addr_reg) &&
                       (bank_sel_reg != s1_bank_reg);
      fwd_data_reg  <= s1_data_reg;
      er_valid_reg  <= scan_rd;
      er_addr_reg   <= scan_addr;
      er_bank_reg   <= bank_sel_reg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] q_reg;
    logic [DW-1:0] wd;
    logic [AW-1:0] wa, ra;
    logic          we, re, is_scan;

    assign is_scan = (bank_sel_reg == 1'(gi));
    assign re      = is_scan ? scan_rd : accept;
    assign ra      = is_scan ? scan_addr : wr_addr;

    // Erase and commit never hit the same bank in one clk: a commit reaches the scan bank
    // only right after a swap, when no scan read preceded it.
    always_comb begin
      we = 1'b0;
      wa = init_cnt_reg;
      wd = '0;
      if (init_active) begin
        we = 1'b1;
      end else if (er_valid_reg && er_bank_reg == 1'(gi)) begin
        we = 1'b1;
        wa = er_addr_reg;
      end else if (commit && s1_bank_reg == 1'(gi)) begin
        we = 1'b1;
        wa = s1_addr_reg;
        wd = s1_data_reg;
      end
    end

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) q_reg <= mem[ra];
    end

    assign bank_q[gi] = q_reg;
  end

endmodule

// File: tb/tb_obj_line_buffer.sv
// Directed bench for obj_line_buffer; a first-wins and a last-wins instance share stimulus.
module tb_obj_line_buffer;
  localparam int DW = 15;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, pxl_cen, lhbl, wr_en;
  logic [8:0]    hpos;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready_a, line_swap_a, wr_ready_b, line_swap_b;
  logic [DW-1:0] rd_a, rd_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] pix_a, pix_b;
  logic          sw_a, sw_b;
  int            n_wait;

  always #5 clk = ~clk;

  obj_line_buffer #(.DW(DW), .AW(AW), .PEN_W(4), .FIRST_WINS(1)) dut_fw (
    .clk(clk), .reset(reset), .pxl_cen(pxl_cen), .lhbl(lhbl), .hpos(hpos),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_a), .line_swap(line_swap_a), .rd_data(rd_a)
  );

  obj_line_buffer #(.DW(DW), .AW(AW), .PEN_W(4), .FIRST_WINS(0)) dut_lw (
    .clk(clk), .reset(reset), .pxl_cen(pxl_cen), .lhbl(lhbl), .hpos(hpos),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_b), .line_swap(line_swap_b), .rd_data(rd_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One pixel: pxl_cen high for one clk, low for one. line_swap is sampled inside the
  // pxl_cen clk, rd_data right after its rising edge.
  task automatic pix(input logic l, input logic [8:0] h);
    pxl_cen = 1'b1;
    lhbl    = l;
    hpos    = h;
    #1;
    sw_a = line_swap_a;
    sw_b = line_swap_b;
    @(negedge clk);
    pix_a   = rd_a;
    pix_b   = rd_b;
    pxl_cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready_a && n < 2000);
  endtask

  task automatic scan_bank(input string tag);
    int bad;
    bad = 0;
    pix(1'b1, 9'd0);
    for (int h = 1; h < 512; h++) begin
      pix(1'b1, 9'(h));
      if (pix_a !== '0 || pix_b !== '0) bad++;
    end
    pix(1'b0, 9'd0);
    if (pix_a !== '0 || pix_b !== '0) bad++;
    check_val({tag, "_nonzero_words"}, bad, 0);
    check_val({tag, "_swap"}, sw_a, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pxl_cen = 1'b0; lhbl = 1'b0; hpos = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk); @(negedge clk);
    check_val("rst_wr_ready", wr_ready_a, 0);
    check_val("rst_line_swap", line_swap_a, 0);
    check_val("rst_rd_data", rd_a, 0);

    // Test 1: clear sequence length and both banks empty
    reset = 1'b0;
    wait_ready(n_wait);
    check_val("init_clks", n_wait, 512);
    check_val("init_ready_b", wr_ready_b, 1);
    scan_bank("bank0");
    scan_bank("bank1");

    // Test 2: write, swap, scan, then erased on the next use of that bank
    wr(9'd5, 15'h0123);
    repeat (2) @(negedge clk);
    pix(1'b1, 9'd0);
    pix(1'b0, 9'd0);
    check_val("t2_swap", sw_a, 1);
    pix(1'b1, 9'd4); pix(1'b1, 9'd5); pix(1'b1, 9'd6);
    check_val("t2_scan_fw", pix_a, 15'h0123);
    check_val("t2_scan_lw", pix_b, 15'h0123);
    pix(1'b0, 9'd0); pix(1'b1, 9'd0); pix(1'b0, 9'd0);
    pix(1'b1, 9'd4); pix(1'b1, 9'd5); pix(1'b1, 9'd6);
    check_val("t2_erased_fw", pix_a, 0);
    check_val("t2_erased_lw", pix_b, 0);
    pix(1'b0, 9'd0);

    // Test 3: overlapping writes, back-to-back and one clk apart
    wr(9'd7, 15'h0011); wr(9'd7, 15'h0022);
    wr(9'd12, 15'h0031); @(negedge clk); wr(9'd12, 15'h0042);
    repeat (2) @(negedge clk);
    pix(1'b1, 9'd0); pix(1'b0, 9'd0);
    pix(1'b1, 9'd6); pix(1'b1, 9'd7); pix(1'b1, 9'd8);
    check_val("t3_b2b_first_wins", pix_a, 15'h0011);
    check_val("t3_b2b_last_wins", pix_b, 15'h0022);
    pix(1'b1, 9'd11); pix(1'b1, 9'd12); pix(1'b1, 9'd13);
    check_val("t3_gap_first_wins", pix_a, 15'h0031);
    check_val("t3_gap_last_wins", pix_b, 15'h0042);
    pix(1'b0, 9'd0);

    // Test 4: transparent source dropped; repeated blank pixels do not swap
    wr(9'd9, 15'h0030);
    repeat (2) @(negedge clk);
    pix(1'b1, 9'd0); pix(1'b0, 9'd0);
    pix(1'b0, 9'd0);
    check_val("t4_no_swap_in_blank", sw_a, 0);
    pix(1'b1, 9'd8); pix(1'b1, 9'd9); pix(1'b1, 9'd10);
    check_val("t4_pen0_fw", pix_a, 0);
    check_val("t4_pen0_lw", pix_b, 0);
    pix(1'b0, 9'd0);

    // Test 5: write accepted in the swap clk lands in the bank now being scanned
    pix(1'b1, 9'd0);
    wr_en = 1'b1; wr_addr = 9'd3; wr_data = 15'h0045;
    pxl_cen = 1'b1; lhbl = 1'b0; hpos = 9'd0;
    #1;
    check_val("t5_swap", line_swap_a, 1);
    check_val("t5_ready", wr_ready_a, 1);
    @(negedge clk);
    wr_en = 1'b0; pxl_cen = 1'b0;
    @(negedge clk);
    pix(1'b1, 9'd2); pix(1'b1, 9'd3); pix(1'b1, 9'd4);
    check_val("t5_scan_fw", pix_a, 15'h0045);
    check_val("t5_scan_lw", pix_b, 15'h0045);
    wr(9'd20, 15'h0077);
    repeat (2) @(negedge clk);

    // Test 6: reset during the clear restarts it from address 0
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_rst_rd_data", rd_a, 0);
    check_val("t6_rst_wr_ready", wr_ready_a, 0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check_val("t6_mid_init_ready", wr_ready_a, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n_wait);
    check_val("t6_restart_clks", n_wait, 512);
    pix(1'b1, 9'd19); pix(1'b1, 9'd20); pix(1'b1, 9'd21);
    check_val("t6_cleared_fw", pix_a, 0);
    check_val("t6_cleared_lw", pix_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
